// File: rtl/mem_ctrl.sv
// Load/store bridge between the control FSM and a simple req/ack word bus.
// Latency: bus_req one cycle after a request is accepted; mfc one cycle after bus_ack, timeout or illegal decode.
// Backpressure: Mem_rd/Mem_wr are held until mfc; the bus stalls the access by withholding bus_ack.
module mem_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Mem_rd,
   input  logic        Mem_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic        mfc,
   output logic [31:0] rdata,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic       we;
      logic [1:0] off;
      logic [2:0] funct3;
   } acc_t;

   state_t        state, state_nxt;
   acc_t          acc;
   logic [CW-1:0] cnt;
   logic          err_q;

   logic          start;
   logic          legal;
   logic [3:0]    be_nxt;
   logic [31:0]   wd_nxt;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_fmt;

   assign start = Mem_rd | Mem_wr;

   // Legality is decided on the raw inputs so an illegal access never reaches the bus.
   always_comb begin
      legal = 1'b1;
      if (Mem_wr)
         legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else
         legal = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
      if ((funct3[1:0] == 2'b01) && addr[0])
         legal = 1'b0;
      if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
         legal = 1'b0;
   end

   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = wdata;
      if (Mem_wr) begin
         case (funct3[1:0])
            2'b00: begin
               be_nxt = 4'b0001 << addr[1:0];
               wd_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_nxt = 4'b0011 << addr[1:0];
               wd_nxt = {2{wdata[15:0]}};
            end
            default: begin
               be_nxt = 4'b1111;
               wd_nxt = wdata;
            end
         endcase
      end
   end

   always_comb begin
      ld_byte = bus_rdata[7:0];
      case (acc.off)
         2'd1:    ld_byte = bus_rdata[15:8];
         2'd2:    ld_byte = bus_rdata[23:16];
         2'd3:    ld_byte = bus_rdata[31:24];
         default: ld_byte = bus_rdata[7:0];
      endcase
      ld_half = acc.off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (acc.funct3)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'd0, ld_byte};
         3'b101:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: begin
            state_nxt = IDLE;
            if (start)
               state_nxt = legal ? REQ : DONE;
         end
         REQ: begin
            state_nxt = REQ;
            if (bus_ack || (cnt == CNT_LAST))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs come from state only, so bus_ack never has a combinational path to them.
   assign bus_req = (state == REQ);
   assign mfc     = (state == DONE);
   assign err     = (state == DONE) && err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         rdata     <= 32'd0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_be    <= 4'd0;
         bus_wdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc.we     <= Mem_wr;
                  acc.off    <= addr[1:0];
                  acc.funct3 <= funct3;
                  bus_we     <= Mem_wr;
                  bus_addr   <= {addr[31:2], 2'b00};
                  bus_be     <= be_nxt;
                  bus_wdata  <= wd_nxt;
                  err_q      <= !legal;
                  cnt        <= '0;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  err_q <= 1'b0;
                  if (!acc.we)
                     rdata <= ld_fmt;
               end else if (cnt == CNT_LAST) begin
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: stimulus pushes expected bus beats and completions, a monitor pops and compares.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Mem_rd = 1'b0;
   logic        Mem_wr = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        mfc;
   logic [31:0] rdata;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   mem_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .addr(addr),
      .wdata(wdata), .funct3(funct3), .mfc(mfc), .rdata(rdata), .err(err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        we;
   } bus_t;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } cpl_t;

   bus_t exp_bus[$];
   cpl_t exp_cpl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compares a bus beat when bus_req rises and a completion on every mfc cycle.
   logic req_prev = 1'b0;
   logic mfc_prev = 1'b0;
   initial begin
      bus_t b;
      cpl_t c;
      forever begin
         @(negedge clk);
         if (bus_req && !req_prev) begin
            if (exp_bus.size() == 0) begin
               chk("unexpected_bus_req", 32'(bus_req), 32'd0);
            end else begin
               b = exp_bus.pop_front();
               chk("bus_addr", bus_addr, b.addr);
               chk("bus_be", 32'(bus_be), 32'(b.be));
               chk("bus_wdata", bus_wdata, b.wd);
               chk("bus_we", 32'(bus_we), 32'(b.we));
            end
         end
         if (mfc_prev)
            chk("mfc_one_cycle", 32'(mfc), 32'd0);
         if (mfc) begin
            if (exp_cpl.size() == 0) begin
               chk("unexpected_mfc", 32'(mfc), 32'd0);
            end else begin
               c = exp_cpl.pop_front();
               chk("err", 32'(err), 32'(c.err));
               chk("rdata", rdata, c.rdata);
            end
         end
         req_prev = bus_req;
         mfc_prev = mfc;
      end
   end

   // One access; ack_wait<0 means the bus never acknowledges. elat = cycles from capture edge to mfc.
   task automatic access(input string nm, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input int ack_wait, input logic [31:0] rw,
                         input logic has_bus, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic eerr, input logic [31:0] erd, input int elat);
      int cyc;
      int nreq;
      bus_t b;
      cpl_t c;
      if (has_bus) begin
         b.addr = {a[31:2], 2'b00};
         b.be   = ebe;
         b.wd   = ewd;
         b.we   = wr;
         exp_bus.push_back(b);
      end
      c.err   = eerr;
      c.rdata = erd;
      exp_cpl.push_back(c);
      Mem_wr = wr;
      Mem_rd = rd;
      addr   = a;
      wdata  = wd;
      funct3 = f3;
      @(posedge clk) #1;
      cyc  = 0;
      nreq = 0;
      while (!mfc && cyc < 100) begin
         if (bus_req)
            nreq++;
         bus_ack   = (ack_wait >= 0) && (cyc == ack_wait);
         bus_rdata = bus_ack ? rw : 32'd0;
         @(posedge clk) #1;
         cyc++;
      end
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      Mem_rd    = 1'b0;
      Mem_wr    = 1'b0;
      chk({nm, "_mfc_latency"}, 32'(cyc), 32'(elat));
      chk({nm, "_bus_req_cycles"}, 32'(nreq), has_bus ? 32'(elat) : 32'd0);
      @(posedge clk) #1;
   endtask

   initial begin
      #12;
      chk("rst_mfc", 32'(mfc), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_be", 32'(bus_be), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //     name   wr    rd    addr          wdata         f3      ack  bus_rdata     bus  be       wdata         err   rdata         lat
      access("lw",  1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 3, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 4);
      access("lb",  1'b0, 1'b1, 32'h103, 32'h0, 3'b000, 0, 32'h80FFFFFF, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hFFFFFF80, 1);
      access("lbu", 1'b0, 1'b1, 32'h103, 32'h0, 3'b100, 1, 32'h80FFFFFF, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h00000080, 2);
      access("sh",  1'b1, 1'b0, 32'h202, 32'h1234ABCD, 3'b001, 2, 32'h0, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h00000080, 3);
      access("lw_misaligned", 1'b0, 1'b1, 32'h101, 32'h0, 3'b010, -1, 32'h0, 1'b0, 4'b0, 32'h0, 1'b1, 32'h00000080, 0);
      access("lh",  1'b0, 1'b1, 32'h102, 32'h0, 3'b001, 0, 32'h80011234, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hFFFF8001, 1);
      access("lhu", 1'b0, 1'b1, 32'h100, 32'h0, 3'b101, 0, 32'h8001F234, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000F234, 1);
      access("sb",  1'b1, 1'b0, 32'h101, 32'h000000A5, 3'b000, 1, 32'h0, 1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0000F234, 2);
      access("st_bad_f3", 1'b1, 1'b0, 32'h100, 32'h0, 3'b100, -1, 32'h0, 1'b0, 4'b0, 32'h0, 1'b1, 32'h0000F234, 0);
      access("ld_bad_f3", 1'b0, 1'b1, 32'h100, 32'h0, 3'b011, -1, 32'h0, 1'b0, 4'b0, 32'h0, 1'b1, 32'h0000F234, 0);
      access("sh_odd", 1'b1, 1'b0, 32'h201, 32'h0, 3'b001, -1, 32'h0, 1'b0, 4'b0, 32'h0, 1'b1, 32'h0000F234, 0);
      access("timeout", 1'b0, 1'b1, 32'h400, 32'h0, 3'b010, -1, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0000F234, 16);

      // Stray bus_ack while idle must not complete anything or touch rdata.
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk) #1;
         chk("idle_ack_no_mfc", 32'(mfc), 32'd0);
      end
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      chk("idle_ack_rdata", rdata, 32'h0000F234);

      // Reset asserted while the bus request is outstanding.
      exp_bus.push_back({32'h500, 4'b1111, 32'h0, 1'b0});
      Mem_rd = 1'b1;
      addr   = 32'h500;
      funct3 = 3'b010;
      @(posedge clk) #1;
      chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
      @(negedge clk) #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_bus_req", 32'(bus_req), 32'd0);
      chk("async_rst_bus_be", 32'(bus_be), 32'd0);
      chk("async_rst_bus_addr", bus_addr, 32'd0);
      chk("async_rst_rdata", rdata, 32'd0);
      Mem_rd = 1'b0;
      @(posedge clk) #1;
      chk("in_rst_mfc", 32'(mfc), 32'd0);
      @(negedge clk) #1;
      rst_n = 1'b1;
      access("rdwr_both", 1'b1, 1'b1, 32'h300, 32'h55AA0FF0, 3'b010, 0, 32'h0, 1'b1, 4'b1111, 32'h55AA0FF0, 1'b0, 32'h0, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
      chk("cpl_queue_drained", 32'(exp_cpl.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
